// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per accepted schedule word, then a
// final chaining add into H. Multi-block messages chain through H.
module sha256_compress #(
   parameter int ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         first_blk,
   input  logic [31:0]  w_in,
   input  logic         w_valid,
   output logic         w_ready,
   output logic [255:0] digest,
   output logic         done,
   output logic         busy
);
   localparam int TW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   localparam logic [0:7][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   state_t           state, state_nx;
   logic [TW-1:0]    t;
   logic [0:7][31:0] h_q;     // chaining value, index 0 = H0
   logic [0:7][31:0] v_q;     // working variables a..h
   logic [0:7][31:0] v_rnd;
   logic [31:0]      s0, s1, ch, maj, t1, t2;
   logic             accept;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // NOTE: combinational blocks use blocking '=' so each temporary is read
   // after it is written in the same evaluation; registers use '<=' only.
   always_comb begin
      s1    = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
      ch    = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
      t1    = v_q[7] + s1 + ch + K_ROM[t] + w_in;
      s0    = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
      maj   = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
      t2    = s0 + maj;
      v_rnd = {t1 + t2, v_q[0], v_q[1], v_q[2],
               v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
   end

   assign accept  = (state == ROUND) && w_valid;
   assign w_ready = (state == ROUND);
   assign busy    = (state == ROUND);
   assign digest  = h_q;

   // NOTE: state_nx gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ROUND;
         ROUND:   if (accept && t == TW'(ROUNDS - 1)) state_nx = FINAL;
         FINAL:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: K_ROM is a constant table and needs no reset; the H and a..h
   // register banks are reset explicitly so an aborted block leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         t     <= '0;
         h_q   <= IV;
         v_q   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == FINAL);
         case (state)
            IDLE: if (start) begin
               h_q <= first_blk ? IV : h_q;
               v_q <= first_blk ? IV : h_q;
               t   <= '0;
            end
            ROUND: if (accept) begin
               v_q <= v_rnd;
               t   <= t + 1'b1;
            end
            FINAL: for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_compress.sv
// Directed vectors for sha256_compress: known-answer digests, chaining,
// stalls, mid-block reset and handshake corner cases.
module tb_sha256_compress;
   typedef logic [0:15][31:0] blk_t;

   typedef struct {
      string        name;
      blk_t         blk;
      logic         first;
      logic         pre_rst;
      logic [255:0] exp;
   } vec_t;

   localparam logic [255:0] IV_D  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMP_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         first_blk = 1'b0;
   logic [31:0]  w_in = '0;
   logic         w_valid = 1'b0;
   logic         w_ready;
   logic [255:0] digest;
   logic         done;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   sha256_compress #(.ROUNDS(64)) dut (
      .clk(clk), .rst(rst), .start(start), .first_blk(first_blk),
      .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready),
      .digest(digest), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return {x, x} >> n;
   endfunction

   // Called and returning at a falling edge; drives reset for one cycle.
   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Expands the block, starts it at the current falling edge and feeds the
   // words. Returns at the falling edge where done is high (or after abort).
   task automatic run_block(input blk_t blk, input logic first, input int stall_pct,
                            input int abort_at, input bit proto,
                            output int lat, output int nstall);
      logic [31:0] w [64];
      logic [31:0] sg0, sg1;
      logic        v;
      int          i;
      for (int k = 0; k < 16; k++) w[k] = blk[k];
      for (int k = 16; k < 64; k++) begin
         sg0  = ror(w[k-15], 7) ^ ror(w[k-15], 18) ^ (w[k-15] >> 3);
         sg1  = ror(w[k-2], 17) ^ ror(w[k-2], 19) ^ (w[k-2] >> 10);
         w[k] = sg1 + w[k-7] + sg0 + w[k-16];
      end
      start     = 1'b1;
      first_blk = first;
      w_valid   = 1'b0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      i      = 0;
      nstall = 0;
      forever begin
         if (done || lat > 400) break;
         start   = 1'b0;
         w_valid = 1'b0;
         if (i == abort_at) begin
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         if (w_ready && i < 64) begin
            start   = proto && (i == 10);
            v       = ($urandom_range(0, 99) >= stall_pct);
            w_valid = v;
            w_in    = v ? w[i] : 32'hdead_beef;
            if (v) i++;
            else nstall++;
         end else if (proto && i == 64) begin
            w_valid = 1'b1;
            w_in    = 32'hbad0_0001;
            check("extra_word_ready", w_ready, 1'b0);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start   = 1'b0;
      w_valid = 1'b0;
      check("done_seen", done, 1'b1);
   endtask

   initial begin
      vec_t vecs [3];
      blk_t abc_b, emp_b, two1_b, two2_b;
      int   lat, nstall, extra;

      abc_b     = '0;
      abc_b[0]  = 32'h61626380;
      abc_b[15] = 32'h00000018;
      emp_b     = '0;
      emp_b[0]  = 32'h80000000;
      two1_b = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      two2_b     = '0;
      two2_b[15] = 32'h000001c0;

      vecs[0] = '{name: "abc",          blk: abc_b, first: 1'b1, pre_rst: 1'b0, exp: ABC_D};
      vecs[1] = '{name: "empty",        blk: emp_b, first: 1'b1, pre_rst: 1'b0, exp: EMP_D};
      vecs[2] = '{name: "abc_chain_iv", blk: abc_b, first: 1'b0, pre_rst: 1'b1, exp: ABC_D};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("rst_digest", digest, IV_D);
      check("rst_busy", busy, 1'b0);
      check("rst_w_ready", w_ready, 1'b0);
      check("rst_done", done, 1'b0);

      foreach (vecs[k]) begin
         if (vecs[k].pre_rst) do_reset();
         run_block(vecs[k].blk, vecs[k].first, 0, -1, 1'b0, lat, nstall);
         check({vecs[k].name, "_digest"}, digest, vecs[k].exp);
         check({vecs[k].name, "_latency"}, lat, 66);
      end

      // Second block starts in the done cycle of the first and chains from it.
      run_block(two1_b, 1'b1, 0, -1, 1'b0, lat, nstall);
      run_block(two2_b, 1'b0, 0, -1, 1'b0, lat, nstall);
      check("two_block_digest", digest, TWO_D);
      check("two_block_latency", lat, 66);

      run_block(abc_b, 1'b1, 40, -1, 1'b0, lat, nstall);
      check("stall_digest", digest, ABC_D);
      check("stall_latency", lat, 66 + nstall);

      // Abort a chained block so H holds a non-IV value when reset arrives.
      run_block(abc_b, 1'b0, 0, 30, 1'b0, lat, nstall);
      check("abort_busy", busy, 1'b0);
      check("abort_w_ready", w_ready, 1'b0);
      check("abort_digest", digest, IV_D);
      check("abort_done", done, 1'b0);
      run_block(abc_b, 1'b1, 0, -1, 1'b0, lat, nstall);
      check("after_abort_digest", digest, ABC_D);

      run_block(abc_b, 1'b1, 0, -1, 1'b1, lat, nstall);
      check("proto_digest", digest, ABC_D);
      check("proto_latency", lat, 66);
      extra = 0;
      repeat (70) begin
         @(posedge clk);
         @(negedge clk);
         if (done) extra++;
      end
      check("proto_single_done", extra, 0);
      check("proto_idle_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression core that sits directly downstream of the message-schedule expander. It consumes the 64 schedule words W[0..63] of one 512-bit block through a valid/ready handshake and runs one compression round per accepted word. After round 63 it adds the working variables into the chaining value and presents the 256-bit digest. Multi-block messages are hashed by chaining successive blocks. The two-block 1024-bit message path is the primary use.

## Interface
- ROUNDS, 64, number of rounds per block; only 64 is legal in product builds, smaller values are for debug only.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin a block; sampled only in IDLE.
- first_blk  input  1  sampled with start; 1 loads the standard IV into H, 0 chains from the current H.
- w_in  input  32  schedule word W[t], t in order 0..63.
- w_valid  input  1  w_in is valid.
- w_ready  output  1  core accepts a word this cycle.
- digest  output  256  {H0..H7}, H0 in bits [255:224].
- done  output  1  one-cycle pulse; digest holds the final value of the block.
- busy  output  1  high from the accepted start until the FINAL update.

## Operation
- States:
  - IDLE: start=1 loads H <= (first_blk ? IV : H) and a..h <= the same value, clears t, then goes to ROUND.
  - ROUND: w_ready=1. On w_valid & w_ready, run one standard round with K[t] from an internal 64-entry ROM and W=w_in, then t<=t+1. The round that accepts t=ROUNDS-1 moves the core to FINAL.
  - FINAL: Hi <= Hi + var_i for all eight words, done<=1, then back to IDLE.
- IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- Arithmetic:
  - All additions are modulo 2^32; carries are discarded.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
- digest is driven directly from the H registers. It changes only on an accepted start (IV load) and in FINAL.
- busy = (state != IDLE) except FINAL, where it is 0.
- w_ready is 0 in IDLE and FINAL.

## Timing
- Reset values:
  - state = IDLE, t = 0.
  - w_ready = 0, done = 0, busy = 0.
  - H = IV, so digest = IV.
  - a..h = 0.
- Reset mid-block aborts the block and restores all reset values on the next edge. Partial round results are discarded.
- Latency with w_valid held high: start sampled at edge 0, words accepted at edges 1..64, FINAL at edge 65. done is high and digest is final in the cycle after edge 65, i.e. 66 cycles after start.
- A cycle with w_valid=0 in ROUND stalls. No state, t or variable changes occur, and latency grows by one per stall cycle.
- w_in is not inspected when w_valid=0.
- start while busy or in FINAL is ignored.
- start is honoured in the cycle where done=1, because the core is in IDLE. With first_blk=0 it chains from the just-updated H.
- first_blk=0 directly after reset chains from IV, giving the same result as first_blk=1.
- Exactly ROUNDS words are accepted per block. A 65th valid word sees w_ready=0.

## Test plan
- Single block "abc": W0=61626380, W1..W14=0, W15=00000018, W16..63 from the bench schedule model; start with first_blk=1 and w_valid held high. Required: done at cycle 66 and digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: W0=80000000, all other W = 0 before expansion. Required: digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block 1024-bit message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first_blk=1; block 2 with first_blk=0, started in the done cycle. Required: digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Stalls: repeat "abc" with w_valid randomly low about 40% of cycles. Required: identical digest, and done latency = 66 + number of stall cycles in ROUND.
- Reset mid-block: drive rst=0 for one cycle after 30 accepted words. Required: next cycle busy=0, w_ready=0, digest=IV. A following "abc" run gives the correct digest.
- Protocol: pulse start at round 10, and offer a word after round 63. Required: the start has no effect, w_ready=0 for the extra word, and a single done pulse occurs.
